// File: rtl/prores_vlc_pkg.sv
// prores_vlc_pkg: shared constants and types for the ProRes VLC front end.
// Holds both AC scan tables (raster position per scan index), the scan
// sequencer FSM state type and the default slice block limit.
package prores_vlc_pkg;

  localparam int DEFAULT_MAX_BLOCKS = 32;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_e;

  localparam logic [5:0] SCAN_PROGRESSIVE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [5:0] SCAN_INTERLACED [64] = '{
    6'd0,  6'd8,  6'd1,  6'd9,  6'd16, 6'd24, 6'd17, 6'd25,
    6'd2,  6'd10, 6'd3,  6'd11, 6'd18, 6'd26, 6'd19, 6'd27,
    6'd32, 6'd40, 6'd33, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49,
    6'd42, 6'd35, 6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd59,
    6'd4,  6'd12, 6'd5,  6'd6,  6'd13, 6'd7,  6'd14, 6'd15,
    6'd20, 6'd28, 6'd21, 6'd22, 6'd29, 6'd23, 6'd30, 6'd31,
    6'd36, 6'd44, 6'd37, 6'd38, 6'd45, 6'd39, 6'd46, 6'd47,
    6'd52, 6'd60, 6'd53, 6'd54, 6'd61, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/ac_scan_addr_gen.sv
// ac_scan_addr_gen: scan index / block counters for the AC scan walk.
// Block is the inner loop, scan index 1..63 the outer loop; the read address
// is block*64 + table[scan_idx]. Table choice is latched on init (only
// meaningful when the top is built with AC_SCAN_INTERLACED_EN).
module ac_scan_addr_gen
  import prores_vlc_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic [5:0]        num_blocks,
  input  logic              interlaced,
  input  logic              advance,
  output logic              last,
  output logic [ADDR_W-1:0] rd_addr
);

  localparam int BLK_W = ADDR_W - 6;

  logic [5:0]       nb_q;
  logic [5:0]       scan_idx_q;
  logic [BLK_W-1:0] blk_q;
  logic             il_q;
  logic             blk_is_last;
  logic [5:0]       pos;

  assign blk_is_last = (32'(blk_q) + 32'd1 == 32'(nb_q));
  assign last        = (scan_idx_q == 6'd63) && blk_is_last;
  assign pos         = il_q ? SCAN_INTERLACED[scan_idx_q] : SCAN_PROGRESSIVE[scan_idx_q];
  assign rd_addr     = {blk_q, pos};

  // Counter update: restart at (idx 1, blk 0) on init, step block-first on advance.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      nb_q       <= '0;
      scan_idx_q <= '0;
      blk_q      <= '0;
      il_q       <= 1'b0;
    end else if (init) begin
      nb_q       <= num_blocks;
      il_q       <= interlaced;
      scan_idx_q <= 6'd1;
      blk_q      <= '0;
    end else if (advance) begin
      if (blk_is_last) begin
        blk_q      <= '0;
        scan_idx_q <= scan_idx_q + 6'd1;
      end else begin
        blk_q <= blk_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ac_scan_sequencer.sv
// ac_scan_sequencer: slice controller for the AC run/level entropy path.
// Reads every coefficient of the slice in scan order, counts zero runs and
// presents one (run, level) symbol per nonzero coefficient; lvl_coeff mirrors
// the accepted level for the level encoder.
// Optional feature: define AC_SCAN_INTERLACED_EN to add the `interlaced` input
// (sampled on start) selecting the interlaced scan table.
module ac_scan_sequencer
  import prores_vlc_pkg::*;
#(
  parameter int MAX_BLOCKS = DEFAULT_MAX_BLOCKS,
  parameter int RUN_W      = 12,
  parameter int ADDR_W     = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [5:0]          num_blocks,
`ifdef AC_SCAN_INTERLACED_EN
  input  logic                interlaced,
`endif
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic signed [31:0]  rd_data,
  output logic                sym_valid,
  input  logic                sym_ready,
  output logic [RUN_W-1:0]    sym_run,
  output logic signed [31:0]  sym_level,
  output logic signed [31:0]  lvl_coeff,
  output logic                slice_start,
  output logic                busy,
  output logic                done
);

  scan_state_e        state_q, state_d;
  logic               start_ok;
  logic               advance;
  logic               last;
  logic [5:0]         nb_eff;
  logic               il_sel;
  logic               rd_vld_q;
  logic               hold_vld_q;
  logic signed [31:0] hold_data_q;
  logic signed [31:0] cur_data;
  logic               cur_vld;
  logic               cur_nz;
  logic               sym_free;
  logic               stall;
  logic               sym_load;
  logic [RUN_W-1:0]   run_q;

`ifdef AC_SCAN_INTERLACED_EN
  assign il_sel = interlaced;
`else
  assign il_sel = 1'b0;
`endif

  assign start_ok = (state_q == IDLE) && start;
  assign nb_eff   = (num_blocks > 6'(MAX_BLOCKS)) ? 6'(MAX_BLOCKS) : num_blocks;

  // The data stage sees either this cycle's read return or a nonzero
  // coefficient parked because the symbol register was full; the two never
  // coexist because parking blocks the next read.
  assign cur_vld  = rd_vld_q | hold_vld_q;
  assign cur_data = hold_vld_q ? hold_data_q : rd_data;
  assign cur_nz   = cur_vld && (cur_data != '0);
  assign sym_free = !sym_valid || sym_ready;
  assign stall    = cur_nz && !sym_free;
  assign sym_load = cur_nz && sym_free;

  assign rd_en     = advance;
  assign busy      = (state_q != IDLE);
  assign lvl_coeff = (sym_valid && sym_ready) ? sym_level : '0;

  ac_scan_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .init       (start_ok),
    .num_blocks (nb_eff),
    .interlaced (il_sel),
    .advance    (advance),
    .last       (last),
    .rd_addr    (rd_addr)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic, read issue and done pulse.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    advance = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (nb_eff == 6'd0) ? DONE : SCAN;
      end
      SCAN: begin
        advance = !stall;
        if (!stall && last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!cur_vld && sym_free) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pipeline flag and slice_start pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q    <= 1'b0;
      slice_start <= 1'b0;
    end else begin
      rd_vld_q    <= advance;
      slice_start <= start_ok;
    end
  end

  // Data stage: absorb zeros into the run, move nonzeros into the symbol
  // register, or park a nonzero while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      run_q       <= '0;
      sym_valid   <= 1'b0;
      sym_run     <= '0;
      sym_level   <= '0;
    end else begin
      hold_vld_q <= stall;
      if (stall) hold_data_q <= cur_data;

      if (start_ok) begin
        run_q <= '0;
      end else if (cur_vld && !cur_nz) begin
        if (run_q != '1) run_q <= run_q + 1'b1;
      end else if (sym_load) begin
        run_q <= '0;
      end

      if (sym_load) begin
        sym_valid <= 1'b1;
        sym_run   <= run_q;
        sym_level <= cur_data;
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ac_scan_sequencer.sv
// tb_ac_scan_sequencer: directed self-checking bench for ac_scan_sequencer.
// Coefficient buffer modelled as an array with one-cycle read latency; a
// negedge monitor logs symbols, reads, done and handshake behaviour per slice.
module tb_ac_scan_sequencer;

  localparam int RUN_W  = 12;
  localparam int ADDR_W = 11;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [5:0]         num_blocks;
`ifdef AC_SCAN_INTERLACED_EN
  logic               interlaced;
`endif
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic signed [31:0] rd_data;
  logic               sym_valid;
  logic               sym_ready;
  logic [RUN_W-1:0]   sym_run;
  logic signed [31:0] sym_level;
  logic signed [31:0] lvl_coeff;
  logic               slice_start;
  logic               busy;
  logic               done;

  ac_scan_sequencer #(
    .MAX_BLOCKS (32),
    .RUN_W      (RUN_W),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .num_blocks  (num_blocks),
`ifdef AC_SCAN_INTERLACED_EN
    .interlaced  (interlaced),
`endif
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_run     (sym_run),
    .sym_level   (sym_level),
    .lvl_coeff   (lvl_coeff),
    .slice_start (slice_start),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int mem [0:2047];
  int cyc = 0;
  int t0  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency buffer; junk on idle cycles so a stray sample shows up.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 32'sh5A5A0000;

  // ---------------------------------------------------------------- logging
  bit   logging = 1'b0;
  int   mrel;
  int   sym_run_q[$];
  int   sym_lvl_q[$];
  int   sym_cyc_q[$];
  int   addr_q[$];
  int   done_cnt, done_cyc, ss_cyc, lvl_bad, hold_bad, stall_cycles;
  bit   busy_at_done;
  bit   prev_stalled;
  int   prev_run, prev_level;

  always @(negedge clk) begin
    if (logging) begin
      mrel = cyc - t0;
      if (sym_valid && sym_ready) begin
        sym_run_q.push_back(int'(sym_run));
        sym_lvl_q.push_back(sym_level);
        sym_cyc_q.push_back(mrel);
        if (lvl_coeff != sym_level) lvl_bad++;
      end else if (lvl_coeff != 0) begin
        lvl_bad++;
      end
      if (prev_stalled && (!sym_valid || int'(sym_run) != prev_run || sym_level != prev_level))
        hold_bad++;
      prev_stalled = sym_valid && !sym_ready;
      prev_run     = int'(sym_run);
      prev_level   = sym_level;
      if (prev_stalled) stall_cycles++;
      if (rd_en) addr_q.push_back(int'(rd_addr));
      if (done) begin
        done_cnt++;
        done_cyc     = mrel;
        busy_at_done = busy;
      end
      if (slice_start) ss_cyc = mrel;
    end
  end

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999999;
  endfunction

  task automatic clear_logs();
    sym_run_q.delete();
    sym_lvl_q.delete();
    sym_cyc_q.delete();
    addr_q.delete();
    done_cnt     = 0;
    done_cyc     = -1;
    ss_cyc       = -1;
    lvl_bad      = 0;
    hold_bad     = 0;
    stall_cycles = 0;
    busy_at_done = 1'b0;
    prev_stalled = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 0;
  endtask

  // Called just after a rising edge: that cycle becomes cycle 0 of the slice.
  // sym_ready is low for cycles [low_start, low_start+low_len); start is
  // pulsed again at restart_at to probe that it is ignored while busy.
  task automatic run_slice(input int nb, input int low_start, input int low_len,
                           input int restart_at);
    clear_logs();
    t0         = cyc;
    start      = 1'b1;
    num_blocks = 6'(nb);
    sym_ready  = 1'b1;
    logging    = 1'b1;
    for (int k = 1; k < 3000 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      start     = (k == restart_at);
      sym_ready = !(k >= low_start && k < low_start + low_len);
    end
    start     = 1'b0;
    sym_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    logging = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    num_blocks = 6'd0;
    sym_ready  = 1'b1;
`ifdef AC_SCAN_INTERLACED_EN
    interlaced = 1'b0;
`endif
    clear_mem();
    clear_logs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",      busy, 0);
    check("reset_rd_en",     rd_en, 0);
    check("reset_rd_addr",   rd_addr, 0);
    check("reset_sym_valid", sym_valid, 0);
    check("reset_done",      done, 0);
    check("reset_lvl_coeff", lvl_coeff, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: one block, all zero
    run_slice(1, 1000, 0, -1);
    check("t1_slice_start", ss_cyc, 1);
    check("t1_done_cyc",    done_cyc, 66);
    check("t1_done_cnt",    done_cnt, 1);
    check("t1_busy_done",   busy_at_done, 1);
    check("t1_syms",        sym_run_q.size(), 0);
    check("t1_lvl_bad",     lvl_bad, 0);
    check("t1_reads",       addr_q.size(), 63);
    check("t1_addr0",       q_at(addr_q, 0), 1);
    check("t1_addr1",       q_at(addr_q, 1), 8);
    check("t1_addr2",       q_at(addr_q, 2), 9);
    check("t1_addr_last",   q_at(addr_q, 62), 63);

    // 2: idx1 = +5 (pos 1), idx3 = -2 (pos 9)
    clear_mem();
    mem[1] = 5;
    mem[9] = -2;
    run_slice(1, 1000, 0, -1);
    check("t2_syms",     sym_run_q.size(), 2);
    check("t2_run0",     q_at(sym_run_q, 0), 0);
    check("t2_lvl0",     q_at(sym_lvl_q, 0), 5);
    check("t2_cyc0",     q_at(sym_cyc_q, 0), 3);
    check("t2_run1",     q_at(sym_run_q, 1), 1);
    check("t2_lvl1",     q_at(sym_lvl_q, 1), -2);
    check("t2_cyc1",     q_at(sym_cyc_q, 1), 5);
    check("t2_done_cyc", done_cyc, 66);
    check("t2_lvl_bad",  lvl_bad, 0);

    // 3: two blocks, only block 1 idx1 = +7; start re-pulsed while busy
    clear_mem();
    mem[65] = 7;
    run_slice(2, 1000, 0, 10);
    check("t3_addr0",    q_at(addr_q, 0), 1);
    check("t3_addr1",    q_at(addr_q, 1), 65);
    check("t3_addr2",    q_at(addr_q, 2), 8);
    check("t3_addr3",    q_at(addr_q, 3), 72);
    check("t3_reads",    addr_q.size(), 126);
    check("t3_syms",     sym_run_q.size(), 1);
    check("t3_run0",     q_at(sym_run_q, 0), 1);
    check("t3_lvl0",     q_at(sym_lvl_q, 0), 7);
    check("t3_done_cyc", done_cyc, 129);
    check("t3_done_cnt", done_cnt, 1);

    // 4: idx1..4 = 1,2,3,4 with sym_ready low for cycles 3..7
    clear_mem();
    mem[1] = 1;
    mem[8] = 2;
    mem[9] = 3;
    mem[2] = 4;
    run_slice(1, 3, 5, -1);
    check("t4_syms",     sym_run_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_run%0d", i), q_at(sym_run_q, i), 0);
      check($sformatf("t4_lvl%0d", i), q_at(sym_lvl_q, i), i + 1);
    end
    check("t4_acc0_cyc", q_at(sym_cyc_q, 0), 8);
    check("t4_acc3_cyc", q_at(sym_cyc_q, 3), 11);
    check("t4_stalls",   stall_cycles, 5);
    check("t4_hold_bad", hold_bad, 0);
    check("t4_reads",    addr_q.size(), 63);
    check("t4_done_cyc", done_cyc, 71);
    check("t4_lvl_bad",  lvl_bad, 0);

    // 5: reset at cycle 20 of a 4-block slice, then a normal slice
    clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = i + 1;
    clear_logs();
    t0         = cyc;
    start      = 1'b1;
    num_blocks = 6'd4;
    logging    = 1'b1;
    repeat (19) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("t5_pre_busy",  busy, 1);
    check("t5_pre_valid", sym_valid, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_rst_busy",      busy, 0);
    check("t5_rst_rd_en",     rd_en, 0);
    check("t5_rst_rd_addr",   rd_addr, 0);
    check("t5_rst_sym_valid", sym_valid, 0);
    check("t5_rst_sym_run",   sym_run, 0);
    check("t5_rst_sym_level", sym_level, 0);
    check("t5_rst_lvl_coeff", lvl_coeff, 0);
    check("t5_rst_slice_st",  slice_start, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    logging = 1'b0;
    check("t5_no_done", done_cnt, 0);
    clear_mem();
    mem[1] = 5;
    mem[9] = -2;
    run_slice(1, 1000, 0, -1);
    check("t5_after_syms", sym_run_q.size(), 2);
    check("t5_after_lvl1", q_at(sym_lvl_q, 1), -2);
    check("t5_after_done", done_cyc, 66);

    // num_blocks = 0: no reads, done and slice_start at cycle 1
    clear_mem();
    run_slice(0, 1000, 0, -1);
    check("t0b_done_cyc", done_cyc, 1);
    check("t0b_ss_cyc",   ss_cyc, 1);
    check("t0b_reads",    addr_q.size(), 0);
    check("t0b_done_cnt", done_cnt, 1);

    // 32 blocks, only the very last coefficient nonzero: longest run
    clear_mem();
    mem[2047] = 7;
    run_slice(32, 1000, 0, -1);
    check("tmax_reads",     addr_q.size(), 2016);
    check("tmax_last_addr", q_at(addr_q, 2015), 2047);
    check("tmax_syms",      sym_run_q.size(), 1);
    check("tmax_run",       q_at(sym_run_q, 0), 2015);
    check("tmax_lvl",       q_at(sym_lvl_q, 0), 7);
    check("tmax_done_cyc",  done_cyc, 2019);

`ifdef AC_SCAN_INTERLACED_EN
    // 6: interlaced table, coefficient at interlaced idx1 (pos 8)
    clear_mem();
    mem[8] = -9;
    interlaced = 1'b1;
    run_slice(1, 1000, 0, -1);
    interlaced = 1'b0;
    check("t6_addr0",    q_at(addr_q, 0), 8);
    check("t6_addr1",    q_at(addr_q, 1), 1);
    check("t6_addr2",    q_at(addr_q, 2), 9);
    check("t6_syms",     sym_run_q.size(), 1);
    check("t6_run0",     q_at(sym_run_q, 0), 0);
    check("t6_lvl0",     q_at(sym_lvl_q, 0), -9);
    check("t6_done_cyc", done_cyc, 66);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
